// File: rtl/pe_result_compactor_if.sv
// Bundles the sparsity-engine beat inputs, the packed-word output stream
// and the status/counter outputs of pe_result_compactor.
//   slave  : the compactor side (consumes beats, drives the stream).
//   master : the environment side (drives beats/flush/out_ready).
// Signals:
//   pe_data/pe_enable/pe_valid : upstream beat (no backpressure)
//   flush                      : request to emit the partial residual word
//   out_data/out_count/out_last/out_valid/out_ready : packed-word stream
//   flush_done, overflow, fifo_level, beat_count, lane_count, drop_count : status
interface pe_result_compactor_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PE_COUNT   = 8,
    parameter int OUT_LANES  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(OUT_LANES + 1);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [PE_COUNT*DATA_WIDTH-1:0]  pe_data;
    logic [PE_COUNT-1:0]             pe_enable;
    logic                            pe_valid;
    logic                            flush;
    logic [OUT_LANES*DATA_WIDTH-1:0] out_data;
    logic [CW-1:0]                   out_count;
    logic                            out_last;
    logic                            out_valid;
    logic                            out_ready;
    logic                            flush_done;
    logic                            overflow;
    logic [LW-1:0]                   fifo_level;
    logic [15:0]                     beat_count;
    logic [15:0]                     lane_count;
    logic [15:0]                     drop_count;

    modport slave (
        input  pe_data, pe_enable, pe_valid, flush, out_ready,
        output out_data, out_count, out_last, out_valid, flush_done,
               overflow, fifo_level, beat_count, lane_count, drop_count
    );

    modport master (
        output pe_data, pe_enable, pe_valid, flush, out_ready,
        input  out_data, out_count, out_last, out_valid, flush_done,
               overflow, fifo_level, beat_count, lane_count, drop_count
    );
endinterface

// File: rtl/pe_result_compactor.sv
// Packs the enabled PE lanes of each beat (ascending lane order) into dense
// OUT_LANES-wide words, buffers them in a small FIFO and presents them on a
// valid/ready stream. A flush emits the partial residual as a short word
// marked last. Beats that would need a push into a full, non-popping FIFO
// are dropped whole, counted, and latch a sticky overflow flag.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : pe_result_compactor_if.slave (beats, flush, stream, status)
module pe_result_compactor #(
    parameter int DATA_WIDTH = 8,
    parameter int PE_COUNT   = 8,
    parameter int OUT_LANES  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    pe_result_compactor_if.slave bus
);
    localparam int CW = $clog2(OUT_LANES + 1);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(2 * OUT_LANES);
    localparam int WW = OUT_LANES * DATA_WIDTH;

    typedef enum logic {IDLE, FLUSH_WAIT} state_t;
    state_t r_state, w_state_next;

    // Residual staging: at most OUT_LANES-1 elements survive a beat.
    logic [DATA_WIDTH-1:0] r_stage [OUT_LANES-1];
    logic [CW-1:0]         r_res_cnt;

    logic [WW-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [CW-1:0]  r_fifo_cnt  [FIFO_DEPTH];
    logic           r_fifo_last [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]  r_level;

    logic           r_overflow, r_flush_done;
    logic [15:0]    r_beat_cnt, r_lane_cnt, r_drop_cnt;

    // Residual followed by this beat's enabled lanes; unused slots are zero
    // so a partial flush word naturally has zeroed upper lanes.
    logic [DATA_WIDTH-1:0] w_comb [2*OUT_LANES];
    logic [CW-1:0]  w_k;
    logic [CW:0]    w_total;
    logic           w_need_push, w_pop, w_can_push, w_drop, w_accept;
    logic           w_exec, w_flush_push, w_push;
    logic [WW-1:0]  w_push_data;
    logic [CW-1:0]  w_push_cnt;

    always_comb begin : merge
        logic [IW-1:0] idx;
        w_k = '0;
        for (int i = 0; i < 2*OUT_LANES; i++) w_comb[i] = '0;
        for (int i = 0; i < OUT_LANES-1; i++)
            if (CW'(i) < r_res_cnt) w_comb[i] = r_stage[i];
        idx = IW'(r_res_cnt);
        for (int i = 0; i < PE_COUNT; i++) begin
            if (bus.pe_valid && bus.pe_enable[i]) begin
                w_comb[idx] = bus.pe_data[i*DATA_WIDTH +: DATA_WIDTH];
                idx = idx + IW'(1);
                w_k = w_k + CW'(1);
            end
        end
    end

    // w_k is already gated by pe_valid, so w_total >= OUT_LANES implies a beat.
    assign w_total     = (CW+1)'(r_res_cnt) + (CW+1)'(w_k);
    assign w_need_push = (w_total >= (CW+1)'(OUT_LANES));
    assign w_pop       = (r_level != '0) && bus.out_ready;
    assign w_can_push  = (r_level < LW'(FIFO_DEPTH)) || w_pop;
    assign w_drop      = w_need_push && !w_can_push;
    assign w_accept    = bus.pe_valid && !w_drop;
    assign w_flush_push = w_exec && (w_total != '0);
    assign w_push      = (w_need_push && w_can_push) || w_flush_push;
    // A full push and a flush push never coincide, so the count selects on need.
    assign w_push_cnt  = w_need_push ? CW'(OUT_LANES) : w_total[CW-1:0];

    generate
        for (genvar gi = 0; gi < OUT_LANES; gi++) begin : g_pack
            assign w_push_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_comb[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // A flush executes only in a cycle without a full-word push and with room;
    // a flush request seen while already waiting is absorbed into the wait.
    always_comb begin
        w_state_next = r_state;
        w_exec       = 1'b0;
        case (r_state)
            IDLE:       if (bus.flush) w_state_next = FLUSH_WAIT;
            FLUSH_WAIT: if (!w_need_push && w_can_push) begin
                            w_exec       = 1'b1;
                            w_state_next = IDLE;
                        end
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_cnt <= '0;
            for (int i = 0; i < OUT_LANES-1; i++) r_stage[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_cnt[i]  <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_flush_done <= 1'b0;
            r_beat_cnt   <= '0;
            r_lane_cnt   <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_accept && w_need_push) begin
                for (int i = 0; i < OUT_LANES-1; i++) r_stage[i] <= w_comb[i+OUT_LANES];
                r_res_cnt <= CW'(w_total - (CW+1)'(OUT_LANES));
            end else if (w_exec) begin
                // The flush word consumed everything, including any same-cycle beat.
                for (int i = 0; i < OUT_LANES-1; i++) r_stage[i] <= '0;
                r_res_cnt <= '0;
            end else if (w_accept) begin
                for (int i = 0; i < OUT_LANES-1; i++) r_stage[i] <= w_comb[i];
                r_res_cnt <= w_total[CW-1:0];
            end

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_cnt[r_wr_ptr]  <= w_push_cnt;
                r_fifo_last[r_wr_ptr] <= !w_need_push;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);

            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
                r_lane_cnt <= r_lane_cnt + 16'(w_k);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_flush_done <= w_exec;
        end
    end

    // Head fields come straight from the FIFO registers, masked to zero when empty.
    assign bus.out_valid  = (r_level != '0);
    assign bus.out_data   = bus.out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.out_count  = bus.out_valid ? r_fifo_cnt[r_rd_ptr]  : '0;
    assign bus.out_last   = bus.out_valid ? r_fifo_last[r_rd_ptr] : 1'b0;
    assign bus.fifo_level = r_level;
    assign bus.flush_done = r_flush_done;
    assign bus.overflow   = r_overflow;
    assign bus.beat_count = r_beat_cnt;
    assign bus.lane_count = r_lane_cnt;
    assign bus.drop_count = r_drop_cnt;
endmodule

// File: tb/tb_pe_result_compactor.sv
// Testbench for pe_result_compactor: directed scenarios followed by random
// traffic, with a byte-queue reference model feeding a word scoreboard that
// a negedge monitor drains whenever the DUT hands over a word.
module tb_pe_result_compactor;
    localparam int DW = 8, PC = 8, OL = 8, FD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    pe_result_compactor_if #(.DATA_WIDTH(DW), .PE_COUNT(PC), .OUT_LANES(OL), .FIFO_DEPTH(FD)) bus ();

    pe_result_compactor #(.DATA_WIDTH(DW), .PE_COUNT(PC), .OUT_LANES(OL), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  cnt;
        logic        last;
    } word_t;

    int vectors = 0;
    int errors  = 0;
    bit mon_en  = 1'b0;

    // Reference model state
    byte unsigned m_res[$];
    word_t        exp_q[$];
    int           m_level = 0;
    bit           m_pending = 1'b0, m_done = 1'b0, m_overflow = 1'b0;
    logic [15:0]  m_beats = '0, m_lanes = '0, m_drops = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic word_t take(input int n, input bit last);
        word_t w;
        w.data = '0;
        for (int j = 0; j < n; j++) w.data[j*8 +: 8] = m_res.pop_front();
        w.cnt  = 4'(n);
        w.last = last;
        return w;
    endfunction

    task automatic model_reset();
        m_res.delete();
        exp_q.delete();
        m_level = 0; m_pending = 0; m_done = 0; m_overflow = 0;
        m_beats = '0; m_lanes = '0; m_drops = '0;
    endtask

    // One clock edge of behaviour, using the inputs currently applied.
    task automatic model_step();
        byte unsigned tent[$];
        bit pop, need, room;
        int k = 0;
        tent = m_res;
        pop  = (m_level > 0) && bus.out_ready;
        if (bus.pe_valid)
            for (int i = 0; i < PC; i++)
                if (bus.pe_enable[i]) begin
                    tent.push_back(bus.pe_data[i*8 +: 8]);
                    k++;
                end
        need = (tent.size() >= OL);
        room = (m_level < FD) || pop;
        if (pop) m_level--;
        m_done = 0;
        if (need && !room) begin
            m_overflow = 1;
            if (m_drops != 16'hFFFF) m_drops++;
        end else begin
            if (bus.pe_valid) begin
                m_beats++;
                m_lanes = m_lanes + 16'(k);
                m_res   = tent;
            end
            if (need) begin
                exp_q.push_back(take(OL, 1'b0));
                m_level++;
            end
        end
        if (m_pending) begin
            if (!need && room) begin
                if (m_res.size() > 0) begin
                    exp_q.push_back(take(m_res.size(), 1'b1));
                    m_level++;
                end
                m_pending = 0;
                m_done    = 1;
            end
        end else if (bus.flush) begin
            m_pending = 1;
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] en, input logic [63:0] d,
                         input bit fl, input bit rdy);
        bus.pe_valid  = v;
        bus.pe_enable = en;
        bus.pe_data   = d;
        bus.flush     = fl;
        bus.out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [63:0] lanes(input logic [7:0] base);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = base + 8'(i + 1);
        return d;
    endfunction

    // Monitor: compares status every cycle and pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid",  64'(bus.out_valid),  64'(m_level > 0));
            check("fifo_level", 64'(bus.fifo_level), 64'(m_level));
            check("overflow",   64'(bus.overflow),   64'(m_overflow));
            check("flush_done", 64'(bus.flush_done), 64'(m_done));
            check("beat_count", 64'(bus.beat_count), 64'(m_beats));
            check("lane_count", 64'(bus.lane_count), 64'(m_lanes));
            check("drop_count", 64'(bus.drop_count), 64'(m_drops));
            if (!bus.out_valid) begin
                check("empty_data", bus.out_data, 64'h0);
            end else if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h, expected no word at %0t", bus.out_data, $time);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    $display("word data=%016h count=%0d last=%0d", bus.out_data, bus.out_count, bus.out_last);
                    check("out_data",  bus.out_data,       w.data);
                    check("out_count", 64'(bus.out_count), 64'(w.cnt));
                    check("out_last",  64'(bus.out_last),  64'(w.last));
                end
            end
        end
    end

    initial begin
        int thr;
        bus.pe_valid = 0; bus.pe_enable = '0; bus.pe_data = '0; bus.flush = 0; bus.out_ready = 0;
        #1 reset = 1'b1;
        #2;
        check("rst_out_valid",  64'(bus.out_valid),  64'h0);
        check("rst_fifo_level", 64'(bus.fifo_level), 64'h0);
        check("rst_beat_count", 64'(bus.beat_count), 64'h0);
        check("rst_overflow",   64'(bus.overflow),   64'h0);
        check("rst_out_data",   bus.out_data,        64'h0);
        #5 reset = 1'b0;
        mon_en = 1'b1;

        // 1: full beat becomes one word on the next cycle
        drive(1, 8'hFF, 64'h0807060504030201, 0, 1);
        check("t1_valid", 64'(bus.out_valid), 64'h1);
        check("t1_data",  bus.out_data, 64'h0807060504030201);
        check("t1_count", 64'(bus.out_count), 64'd8);
        check("t1_beats", 64'(bus.beat_count), 64'd1);
        check("t1_lanes", 64'(bus.lane_count), 64'd8);
        drive(0, 0, 0, 0, 1);

        // 2: two half beats merge into one word
        drive(1, 8'h0F, lanes(8'h00), 0, 1);
        check("t2_no_word", 64'(bus.out_valid), 64'h0);
        drive(1, 8'hF0, lanes(8'h10), 0, 1);
        check("t2_data",  bus.out_data, 64'h1817161504030201);
        check("t2_count", 64'(bus.out_count), 64'd8);
        drive(0, 0, 0, 0, 1);

        // 3: partial word via flush
        drive(1, 8'h05, lanes(8'h00), 0, 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        check("t3_data", bus.out_data, 64'h0301);
        check("t3_count", 64'(bus.out_count), 64'd2);
        check("t3_last", 64'(bus.out_last), 64'h1);
        check("t3_done", 64'(bus.flush_done), 64'h1);
        drive(0, 0, 0, 0, 1);
        check("t3_done_pulse", 64'(bus.flush_done), 64'h0);

        // 4: overflow with a stalled consumer, then drain
        for (int b = 0; b < 5; b++) drive(1, 8'hFF, lanes(8'(8'h20 + 8*b)), 0, 0);
        check("t4_level", 64'(bus.fifo_level), 64'd4);
        check("t4_ovf",   64'(bus.overflow),   64'h1);
        check("t4_drops", 64'(bus.drop_count), 64'd1);
        check("t4_beats", 64'(bus.beat_count), 64'd8);
        check("t4_lanes", 64'(bus.lane_count), 64'd50);
        for (int b = 0; b < 5; b++) drive(0, 0, 0, 0, 1);
        check("t4_ovf_sticky", 64'(bus.overflow), 64'h1);

        // 5: flush with nothing staged
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        check("t5_valid", 64'(bus.out_valid), 64'h0);
        check("t5_done", 64'(bus.flush_done), 64'h1);

        // 6: asynchronous reset with queued words and a residual
        drive(1, 8'hFF, lanes(8'h40), 0, 0);
        drive(1, 8'hFF, lanes(8'h50), 0, 0);
        drive(1, 8'h07, lanes(8'h60), 0, 0);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("t6_valid", 64'(bus.out_valid), 64'h0);
        check("t6_level", 64'(bus.fifo_level), 64'h0);
        check("t6_beats", 64'(bus.beat_count), 64'h0);
        check("t6_lanes", 64'(bus.lane_count), 64'h0);
        check("t6_drops", 64'(bus.drop_count), 64'h0);
        check("t6_ovf",   64'(bus.overflow),   64'h0);
        #3 reset = 1'b0;
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        check("t6_flush_valid", 64'(bus.out_valid), 64'h0);
        check("t6_flush_done", 64'(bus.flush_done), 64'h1);

        // Random traffic with varying consumer throughput
        for (int blk = 0; blk < 6; blk++) begin
            thr = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 90 : 55);
            for (int c = 0; c < 100; c++)
                drive(($urandom % 4) != 0, 8'($urandom), {$urandom, $urandom},
                      ($urandom % 12) == 0, ($urandom % 100) < thr);
        end

        // Drain: flush the residual, then run until the model is empty (bounded)
        drive(0, 0, 0, 1, 1);
        for (int c = 0; c < 60 && (exp_q.size() > 0 || m_level > 0 || m_pending); c++)
            drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
